// File: rtl/pixel_rom_arbiter.sv
// ----------------------------------------------------------------------------
// pixel_rom_arbiter
//
// Round-robin arbiter sharing one single-port sprite/tile pixel ROM read port
// among NUM_REQ sprite renderers. Each accepted request gets a one-cycle
// registered grant. The ROM read data returns MEM_LAT cycles later, tagged with
// a one-hot rvalid. A saturating per-frame grant counter is cleared by
// frame_start.
//
// Optional feature macro: PRIORITY_LOCK_EN
//   defined   : requester 0 (player sprite) always wins while req[0]=1. The
//               pointer only advances on grants to requesters 1..NUM_REQ-1.
//   undefined : pure round-robin over all requesters.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle pulse at start of frame
//   req          in   [NUM_REQ]        level requests
//   addr         in   [NUM_REQ*ADDR_W] flattened per-requester addresses
//   gnt          out  [NUM_REQ]        registered one-hot grant
//   mem_en       out  ROM read enable
//   mem_addr     out  [ADDR_W]         ROM address
//   mem_data     in   [DATA_W]         ROM data, valid MEM_LAT cycles after mem_en
//   rvalid       out  [NUM_REQ]        one-hot return tag
//   rdata        out  [DATA_W]         mem_data while any rvalid bit set, else 0
//   frame_grants out  [16]             grants since last frame_start, saturating
// ----------------------------------------------------------------------------
module pixel_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [15:0]               frame_grants
);

  localparam int               PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]   NUM_REQ_EXT = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0] ONE_PTR     = PTR_W'(1);
  localparam logic [15:0]      FG_MAX      = 16'hFFFF;

  // Registered state
  logic [PTR_W-1:0]   ptr_r;
  logic [NUM_REQ-1:0] gnt_r;
  logic               mem_en_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [15:0]        fg_r;
  logic [NUM_REQ-1:0] pipe_r [MEM_LAT];

  // Arbitration signals
  logic               any_req_s;
  logic [NUM_REQ-1:0] rot_s;
  logic               found_s;
  logic [PTR_W-1:0]   off_s;
  logic [PTR_W:0]     sum_s;
  logic [PTR_W-1:0]   rr_win_s;
  logic [PTR_W-1:0]   win_s;
  logic               adv_s;
  logic [NUM_REQ-1:0] win_oh_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [PTR_W-1:0]   next_ptr_s;

  // Round-robin search: rotate req so ptr sits at bit 0, take the first set
  // bit, then map the offset back to an absolute requester index.
  always_comb begin
    any_req_s = |req;
    rot_s     = NUM_REQ'({req, req} >> ptr_r);
    found_s   = 1'b0;
    off_s     = {PTR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && rot_s[k]) begin
        found_s = 1'b1;
        off_s   = PTR_W'(k);
      end else begin
        found_s = found_s;
      end
    end
    sum_s    = {1'b0, ptr_r} + {1'b0, off_s};
    rr_win_s = PTR_W'((sum_s >= NUM_REQ_EXT) ? (sum_s - NUM_REQ_EXT) : sum_s);
  end

  // Final winner selection and whether this grant moves the pointer.
  always_comb begin
`ifdef PRIORITY_LOCK_EN
    // The player sprite overrides the rotation and leaves the pointer alone.
    if (req[0]) begin
      win_s = {PTR_W{1'b0}};
      adv_s = 1'b0;
    end else begin
      win_s = rr_win_s;
      adv_s = any_req_s;
    end
`else
    win_s = rr_win_s;
    adv_s = any_req_s;
`endif
  end

  // One-hot grant vector, winner address mux and wrapped next pointer.
  always_comb begin
    win_oh_s   = {NUM_REQ{1'b0}};
    sel_addr_s = {ADDR_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (any_req_s && (win_s == PTR_W'(k))) begin
        win_oh_s[k] = 1'b1;
        sel_addr_s  = addr[k*ADDR_W +: ADDR_W];
      end else begin
        win_oh_s[k] = 1'b0;
      end
    end
    if (win_s == LAST_IDX) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = win_s + ONE_PTR;
    end
  end

  // Grant, ROM enable and ROM address registers; address holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r      <= {NUM_REQ{1'b0}};
      mem_en_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
    end else if (any_req_s) begin
      gnt_r      <= win_oh_s;
      mem_en_r   <= 1'b1;
      mem_addr_r <= sel_addr_s;
    end else begin
      gnt_r      <= {NUM_REQ{1'b0}};
      mem_en_r   <= 1'b0;
      mem_addr_r <= mem_addr_r;
    end
  end

  // Rotating pointer. A grant on the frame_start edge wins over the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (adv_s) begin
      ptr_r <= next_ptr_s;
    end else if (frame_start) begin
      ptr_r <= {PTR_W{1'b0}};
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Per-frame saturating grant counter; a grant on frame_start counts as 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_r <= 16'h0000;
    end else if (frame_start) begin
      fg_r <= any_req_s ? 16'h0001 : 16'h0000;
    end else if (any_req_s && (fg_r != FG_MAX)) begin
      fg_r <= fg_r + 16'h0001;
    end else begin
      fg_r <= fg_r;
    end
  end

  // Return-tag delay line matching the ROM latency; reset drops in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_r[i] <= {NUM_REQ{1'b0}};
      end
    end else begin
      pipe_r[0] <= gnt_r;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign gnt          = gnt_r;
  assign mem_en       = mem_en_r;
  assign mem_addr     = mem_addr_r;
  assign rvalid       = pipe_r[MEM_LAT-1];
  assign frame_grants = fg_r;
  // Zero means transparent to the compositor, so idle cycles must read as 0.
  assign rdata        = (|pipe_r[MEM_LAT-1]) ? mem_data : {DATA_W{1'b0}};

endmodule

// File: tb/tb_pixel_rom_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for pixel_rom_arbiter: directed stimulus, a behavioural reference
// model of the arbitration rules compared every cycle, and hand-computed
// literal expectations for the key scenarios.
// ----------------------------------------------------------------------------
module tb_pixel_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 12;
  localparam int MEM_LAT = 2;

  logic                      clk;
  logic                      rst_n;
  logic                      frame_start;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic                      mem_en;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_data;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic [15:0]               frame_grants;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  pixel_rom_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .req         (req),
    .addr        (addr),
    .gnt         (gnt),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .frame_grants(frame_grants)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM contents: never zero so the rdata gating is visible.
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] t;
    t = a * 17'd37 + 17'd1441;
    return t[DATA_W-1:0] | 12'h001;
  endfunction

  // ROM stub: data appears MEM_LAT cycles after the address is presented.
  logic [ADDR_W-1:0] rom_pipe [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) rom_pipe[i] = '0;
  always @(posedge clk) begin
    rom_pipe[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign mem_data = rom_f(rom_pipe[MEM_LAT-1]);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [NUM_REQ-1:0] tag;
    logic [ADDR_W-1:0]  addr;
  } ret_t;

  ret_t               ret_q[$];
  int                 m_ptr        = 0;
  logic [NUM_REQ-1:0] exp_gnt      = '0;
  logic               exp_mem_en   = 1'b0;
  logic [ADDR_W-1:0]  exp_mem_addr = '0;
  logic [NUM_REQ-1:0] exp_rvalid   = '0;
  logic [DATA_W-1:0]  exp_rdata    = '0;
  int                 exp_fg       = 0;

  task automatic model_reset();
    m_ptr = 0; exp_gnt = '0; exp_mem_en = 1'b0; exp_mem_addr = '0;
    exp_rvalid = '0; exp_rdata = '0; exp_fg = 0;
    ret_q.delete();
  endtask

  task automatic model_step();
    int   win;
    int   idx;
    bit   adv;
    ret_t e;
    // Each finished cycle's grant comes back exactly MEM_LAT cycles later.
    e.tag  = exp_gnt;
    e.addr = exp_mem_addr;
    ret_q.push_back(e);
    while (ret_q.size() > MEM_LAT) void'(ret_q.pop_front());
    if (ret_q.size() == MEM_LAT && ret_q[0].tag != '0) begin
      exp_rvalid = ret_q[0].tag;
      exp_rdata  = rom_f(ret_q[0].addr);
    end else begin
      exp_rvalid = '0;
      exp_rdata  = '0;
    end
    win = -1;
`ifdef PRIORITY_LOCK_EN
    if (req[0]) win = 0;
`endif
    if (win < 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (win < 0 && req[idx]) win = idx;
      end
    end
    adv = (win >= 0);
`ifdef PRIORITY_LOCK_EN
    if (win == 0) adv = 1'b0;
`endif
    if (frame_start) m_ptr = 0;
    if (adv) m_ptr = (win + 1) % NUM_REQ;
    exp_gnt = '0;
    if (win >= 0) begin
      exp_gnt[win] = 1'b1;
      exp_mem_en   = 1'b1;
      exp_mem_addr = addr[win*ADDR_W +: ADDR_W];
    end else begin
      exp_mem_en = 1'b0;
    end
    if (frame_start) exp_fg = (win >= 0) ? 1 : 0;
    else if (win >= 0 && exp_fg < 65535) exp_fg++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every output against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_gnt",    32'(gnt),          32'(exp_gnt));
        chk("m_mem_en", 32'(mem_en),       32'(exp_mem_en));
        chk("m_maddr",  32'(mem_addr),     32'(exp_mem_addr));
        chk("m_rvalid", 32'(rvalid),       32'(exp_rvalid));
        chk("m_rdata",  32'(rdata),        32'(exp_rdata));
        chk("m_fg",     32'(frame_grants), 32'(exp_fg));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_slice(input int i, input logic [ADDR_W-1:0] v);
    addr[i*ADDR_W +: ADDR_W] = v;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"},    32'(gnt),          32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en),       32'h0);
    chk({tag, "_maddr"},  32'(mem_addr),     32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid),       32'h0);
    chk({tag, "_rdata"},  32'(rdata),        32'h0);
    chk({tag, "_fg"},     32'(frame_grants), 32'h0);
  endtask

  task automatic do_reset();
    req = '0; frame_start = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [NUM_REQ-1:0] ord [6];
  logic [NUM_REQ-1:0] s_gnt [9];
  logic [ADDR_W-1:0]  s_ma  [9];
  logic [NUM_REQ-1:0] s_rv  [9];
  logic [DATA_W-1:0]  s_rd  [9];
  logic [NUM_REQ-1:0] lk_exp;

  initial begin
    rst_n = 1'b1; frame_start = 1'b0; req = '0; addr = '0;
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100;
    ord[3] = 4'b1000; ord[4] = 4'b0001; ord[5] = 4'b0010;
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst0");
    chk_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Full contention from reset: 0,1,2,3,0,1 and six grants counted.
    for (int i = 0; i < NUM_REQ; i++) set_slice(i, 17'h01000 + 17'(i));
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("cont_order", 32'(gnt), 32'(ord[k]));
    end
    chk("cont_fg6", 32'(frame_grants), 32'd6);
    req = '0;
    repeat (4) tick();

    // Reset mid-operation (pointer now at 2): two grants, one cycle, reset.
    req = 4'b1100;
    tick();
    chk("mid_g1", 32'(gnt), 32'h4);
    tick();
    chk("mid_g2", 32'(gnt), 32'h8);
    req = '0;
    tick();
    chk("mid_rv_pre", 32'(rvalid), 32'h4);
    rst_n = 1'b0;
    #1 check_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mid_rv_post", 32'(rvalid), 32'h0);
    end
    req = 4'b1010;
    tick();
    chk("mid_lowest", 32'(gnt), 32'h2);
    req = '0;
    repeat (4) tick();

    // Single streamer on requester 2, address advancing every grant.
    set_slice(2, 17'h00100);
    req = 4'b0100;
    for (int j = 1; j <= 8; j++) begin
      tick();
      s_gnt[j] = gnt; s_ma[j] = mem_addr; s_rv[j] = rvalid; s_rd[j] = rdata;
      if (j < 5) set_slice(2, 17'h00100 + 17'(j));
      else req = '0;
    end
    for (int j = 1; j <= 5; j++) begin
      chk("str_gnt",  32'(s_gnt[j]), 32'h4);
      chk("str_addr", 32'(s_ma[j]),  32'h100 + 32'(j - 1));
    end
    chk("str_gnt_end", 32'(s_gnt[6]), 32'h0);
    for (int j = 1; j <= 8; j++) begin
      if (j >= 3 && j <= 7) begin
        chk("str_rv", 32'(s_rv[j]), 32'h4);
        chk("str_rd", 32'(s_rd[j]), 32'(rom_f(17'h00100 + 17'(j - 3))));
      end else begin
        chk("str_rv0", 32'(s_rv[j]), 32'h0);
        chk("str_rd0", 32'(s_rd[j]), 32'h0);
      end
    end
    repeat (3) tick();

    // Frame restart: grants 0,1, then frame_start alone, then all request.
    do_reset();
    req = 4'b0011;
    tick();
    chk("fr_g0", 32'(gnt), 32'h1);
    tick();
    chk("fr_g1", 32'(gnt), 32'h2);
    req = '0;
    frame_start = 1'b1;
    tick();
    chk("fr_fg0", 32'(frame_grants), 32'h0);
    frame_start = 1'b0;
    req = 4'b1111;
    tick();
    chk("fr_next", 32'(gnt), 32'h1);
    chk("fr_fg1", 32'(frame_grants), 32'h1);
    req = '0;
    repeat (4) tick();

    // Requesters 0 and 3 held for ten cycles, then requester 0 drops.
    do_reset();
    req = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      tick();
`ifdef PRIORITY_LOCK_EN
      lk_exp = 4'b0001;
`else
      lk_exp = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      chk("lock_gnt", 32'(gnt), 32'(lk_exp));
    end
    req = 4'b1000;
    tick();
    chk("lock_drop", 32'(gnt), 32'h8);
    req = '0;
    repeat (4) tick();

    // Saturation: 70000 back-to-back grants without frame_start.
    do_reset();
    req = 4'b0001;
    repeat (70000) tick();
    chk("sat_fg", 32'(frame_grants), 32'hFFFF);
    req = '0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
